// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with load-use hazard detection.
//            Each rising edge does exactly one of the following, in priority
//            order:
//              - flush : write a bubble into EX.
//              - stall : write a bubble into EX.
//              - load  : copy the ID slot into EX.
//            Saturating counters record bubbles and flushes.
// Ports    : clk, reset (async, active-high)
//            id_*            : decoded instruction presented by ID
//            flush           : taken branch/jump in EX, kill the ID slot
//            ex_*            : registered EX-stage copy of the instruction
//            load_use_stall  : combinational, freezes PC and IF/ID
//            bubble_cnt      : saturating count of stall bubbles
//            flush_cnt       : saturating count of flush bubbles
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      id_rd1,
  input  logic [31:0]      id_rd2,
  input  logic [31:0]      id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_RegWrite,
  input  logic             id_MemWrite,
  input  logic             id_ALUSrc,
  input  logic [4:0]       id_ALUOp,
  input  logic [2:0]       id_NPCOp,
  input  logic [1:0]       id_WDSel,
  input  logic [2:0]       id_dm_ctrl,
  input  logic             flush,
  output logic             ex_valid,
  output logic [31:0]      ex_pc,
  output logic [31:0]      ex_rd1,
  output logic [31:0]      ex_rd2,
  output logic [31:0]      ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic             ex_RegWrite,
  output logic             ex_MemWrite,
  output logic             ex_ALUSrc,
  output logic [4:0]       ex_ALUOp,
  output logic [2:0]       ex_NPCOp,
  output logic [1:0]       ex_WDSel,
  output logic [2:0]       ex_dm_ctrl,
  output logic             load_use_stall,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0]       c_wdsel_mem = 2'b01;
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max   = '1;

  // An instruction in EX that writes a nonzero register from memory, whose
  // result an ID instruction needs before it is available.
  logic w_ex_is_load;
  logic w_src_match;
  logic w_hazard;
  logic w_load;

  assign w_ex_is_load   = ex_valid & ex_RegWrite & (ex_WDSel == c_wdsel_mem) & (ex_rd != 5'd0);
  assign w_src_match    = (id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd));
  assign w_hazard       = w_ex_is_load & w_src_match & id_valid;
  // A flush kills the dependent instruction anyway, so it never needs a stall.
  assign load_use_stall = w_hazard & ~flush;
  assign w_load         = ~flush & ~load_use_stall;

  // Next EX contents: an all-zero bubble unless the ID slot is loaded.
  logic        w_valid;
  logic [31:0] w_pc, w_rd1, w_rd2, w_imm;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic        w_regwrite, w_memwrite, w_alusrc;
  logic [4:0]  w_aluop;
  logic [2:0]  w_npcop;
  logic [1:0]  w_wdsel;
  logic [2:0]  w_dm_ctrl;

  always_comb begin
    w_valid    = 1'b0;
    w_pc       = 32'd0;
    w_rd1      = 32'd0;
    w_rd2      = 32'd0;
    w_imm      = 32'd0;
    w_rs1      = 5'd0;
    w_rs2      = 5'd0;
    w_rd       = 5'd0;
    w_regwrite = 1'b0;
    w_memwrite = 1'b0;
    w_alusrc   = 1'b0;
    w_aluop    = 5'd0;
    w_npcop    = 3'd0;
    w_wdsel    = 2'd0;
    w_dm_ctrl  = 3'd0;
    if (w_load) begin
      w_valid = id_valid;
      w_pc    = id_pc;
      w_rd1   = id_rd1;
      w_rd2   = id_rd2;
      w_imm   = id_imm;
      w_rs1   = id_rs1;
      w_rs2   = id_rs2;
      w_rd    = id_rd;
      // An empty ID slot must not carry live control into EX.
      if (id_valid) begin
        w_regwrite = id_RegWrite;
        w_memwrite = id_MemWrite;
        w_alusrc   = id_ALUSrc;
        w_aluop    = id_ALUOp;
        w_npcop    = id_NPCOp;
        w_wdsel    = id_WDSel;
        w_dm_ctrl  = id_dm_ctrl;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_pc       <= 32'd0;
      ex_rd1      <= 32'd0;
      ex_rd2      <= 32'd0;
      ex_imm      <= 32'd0;
      ex_rs1      <= 5'd0;
      ex_rs2      <= 5'd0;
      ex_rd       <= 5'd0;
      ex_RegWrite <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_ALUOp    <= 5'd0;
      ex_NPCOp    <= 3'd0;
      ex_WDSel    <= 2'd0;
      ex_dm_ctrl  <= 3'd0;
      bubble_cnt  <= '0;
      flush_cnt   <= '0;
    end else begin
      ex_valid    <= w_valid;
      ex_pc       <= w_pc;
      ex_rd1      <= w_rd1;
      ex_rd2      <= w_rd2;
      ex_imm      <= w_imm;
      ex_rs1      <= w_rs1;
      ex_rs2      <= w_rs2;
      ex_rd       <= w_rd;
      ex_RegWrite <= w_regwrite;
      ex_MemWrite <= w_memwrite;
      ex_ALUSrc   <= w_alusrc;
      ex_ALUOp    <= w_aluop;
      ex_NPCOp    <= w_npcop;
      ex_WDSel    <= w_wdsel;
      ex_dm_ctrl  <= w_dm_ctrl;
      // Counters stick at all-ones instead of wrapping.
      if (flush) begin
        if (flush_cnt != c_cnt_max) flush_cnt <= flush_cnt + c_cnt_one;
      end else if (load_use_stall) begin
        if (bubble_cnt != c_cnt_max) bubble_cnt <= bubble_cnt + c_cnt_one;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Self-checking bench for id_ex_stage (CNT_W=4 so that counter
//            saturation is reachable quickly).
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = 15;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        regwrite, memwrite, alusrc;
    logic [4:0]  aluop;
    logic [2:0]  npcop;
    logic [1:0]  wdsel;
    logic [2:0]  dmctrl;
  } ex_t;

  logic clk = 1'b0;
  logic reset;
  ex_t  id_in;
  logic use1, use2, flush;

  logic             ex_valid, ex_RegWrite, ex_MemWrite, ex_ALUSrc;
  logic [31:0]      ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd, ex_ALUOp;
  logic [2:0]       ex_NPCOp, ex_dm_ctrl;
  logic [1:0]       ex_WDSel;
  logic             load_use_stall;
  logic [CNT_W-1:0] bubble_cnt, flush_cnt;
  ex_t              d_ex;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_in.valid), .id_pc(id_in.pc), .id_rd1(id_in.rd1),
    .id_rd2(id_in.rd2), .id_imm(id_in.imm),
    .id_rs1(id_in.rs1), .id_rs2(id_in.rs2), .id_rd(id_in.rd),
    .id_use_rs1(use1), .id_use_rs2(use2),
    .id_RegWrite(id_in.regwrite), .id_MemWrite(id_in.memwrite),
    .id_ALUSrc(id_in.alusrc), .id_ALUOp(id_in.aluop), .id_NPCOp(id_in.npcop),
    .id_WDSel(id_in.wdsel), .id_dm_ctrl(id_in.dmctrl),
    .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite), .ex_ALUSrc(ex_ALUSrc),
    .ex_ALUOp(ex_ALUOp), .ex_NPCOp(ex_NPCOp), .ex_WDSel(ex_WDSel),
    .ex_dm_ctrl(ex_dm_ctrl), .load_use_stall(load_use_stall),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  assign d_ex = {ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
                 ex_RegWrite, ex_MemWrite, ex_ALUSrc, ex_ALUOp, ex_NPCOp,
                 ex_WDSel, ex_dm_ctrl};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_ex(input string name, input ex_t act, input ex_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  ex_t m_ex;
  int  m_bub, m_fl;

  // The ID instruction must wait when EX holds a real load into a nonzero
  // register that ID reads, unless ID is being killed anyway.
  function automatic logic exp_stall();
    logic ex_is_load;
    logic reads_it;
    ex_is_load = m_ex.valid && m_ex.regwrite && (m_ex.wdsel == 2'b01) && (m_ex.rd != 5'd0);
    reads_it   = (use1 && id_in.rs1 == m_ex.rd) || (use2 && id_in.rs2 == m_ex.rd);
    if (flush || !id_in.valid || !ex_is_load) return 1'b0;
    return reads_it;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ex  = '0;
      m_bub = 0;
      m_fl  = 0;
    end else if (flush) begin
      m_ex = '0;
      m_fl = (m_fl < CNT_MAX) ? m_fl + 1 : CNT_MAX;
    end else if (exp_stall()) begin
      m_ex  = '0;
      m_bub = (m_bub < CNT_MAX) ? m_bub + 1 : CNT_MAX;
    end else begin
      m_ex = id_in;
      if (!id_in.valid) begin
        m_ex.regwrite = 1'b0; m_ex.memwrite = 1'b0; m_ex.alusrc = 1'b0;
        m_ex.aluop = '0; m_ex.npcop = '0; m_ex.wdsel = '0; m_ex.dmctrl = '0;
      end
    end
  end

  // One compare per cycle, away from the active edge.
  always @(negedge clk) begin
    chk_ex("ex_fields", d_ex, m_ex);
    chk("load_use_stall", 32'(load_use_stall), 32'(exp_stall()));
    chk("bubble_cnt", 32'(bubble_cnt), m_bub);
    chk("flush_cnt", 32'(flush_cnt), m_fl);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic nop();
    id_in = '0; use1 = 1'b0; use2 = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  task automatic set_lw(input logic [4:0] rd, input logic [31:0] pc);
    nop();
    id_in.valid = 1'b1; id_in.pc = pc; id_in.rd = rd; id_in.rs1 = 5'd2;
    id_in.imm = 32'h10; id_in.rd1 = 32'h2000;
    id_in.regwrite = 1'b1; id_in.alusrc = 1'b1; id_in.wdsel = 2'b01;
    id_in.dmctrl = 3'b010; use1 = 1'b1;
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] pc);
    nop();
    id_in.valid = 1'b1; id_in.pc = pc; id_in.rd = rd; id_in.rs1 = rs1;
    id_in.rs2 = rs2; id_in.rd1 = 32'hAAAA_0001; id_in.rd2 = 32'h5555_0002;
    id_in.regwrite = 1'b1; id_in.aluop = 5'b00001; use1 = 1'b1; use2 = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    nop();
    @(posedge clk);
    #2;
    reset = 1'b0;
    chk("reset_valid", 32'(ex_valid), 32'd0);
    chk("reset_cnts", 32'({bubble_cnt, flush_cnt}), 32'd0);

    // Plain load, one-cycle latency.
    nop();
    id_in.valid = 1'b1; id_in.pc = 32'h100; id_in.aluop = 5'b00011;
    id_in.regwrite = 1'b1; id_in.npcop = 3'b001; id_in.rd = 5'd3;
    step();
    chk("load_pc", ex_pc, 32'h100);
    chk("load_aluop", 32'(ex_ALUOp), 32'h3);
    chk("load_regwrite", 32'(ex_RegWrite), 32'd1);
    chk("load_valid", 32'(ex_valid), 32'd1);

    // Load-use on rs1: one stall cycle, then the add loads.
    do_reset();
    set_lw(5'd5, 32'h200);
    step();
    set_alu(5'd6, 5'd5, 5'd7, 32'h204);
    #1;
    chk("lu_stall", 32'(load_use_stall), 32'd1);
    step();
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_bubble_cnt", 32'(bubble_cnt), 32'd1);
    chk("lu_stall_drop", 32'(load_use_stall), 32'd0);
    step();
    chk("lu_add_valid", 32'(ex_valid), 32'd1);
    chk("lu_add_rd", 32'(ex_rd), 32'd6);
    chk("lu_add_pc", ex_pc, 32'h204);

    // No false stalls: x0 load, non-load writer, unused source, empty ID slot.
    do_reset();
    set_lw(5'd0, 32'h300);
    step();
    set_alu(5'd6, 5'd0, 5'd0, 32'h304);
    #1;
    chk("x0_no_stall", 32'(load_use_stall), 32'd0);
    set_alu(5'd5, 5'd1, 5'd0, 32'h308);
    step();
    set_alu(5'd6, 5'd5, 5'd0, 32'h30C);
    #1;
    chk("alu_no_stall", 32'(load_use_stall), 32'd0);
    set_lw(5'd9, 32'h310);
    step();
    set_alu(5'd6, 5'd1, 5'd9, 32'h314);
    use2 = 1'b0;
    #1;
    chk("unused_rs2_no_stall", 32'(load_use_stall), 32'd0);
    id_in.valid = 1'b0; use2 = 1'b1; id_in.memwrite = 1'b1;
    #1;
    chk("empty_id_no_stall", 32'(load_use_stall), 32'd0);
    chk("no_false_bubble", 32'(bubble_cnt), 32'd0);
    step();
    chk("empty_ctrl_zero", 32'({ex_valid, ex_RegWrite, ex_MemWrite, ex_ALUOp}), 32'd0);
    chk("empty_pc_copied", ex_pc, 32'h314);
    set_lw(5'd9, 32'h318);
    step();
    set_alu(5'd6, 5'd1, 5'd9, 32'h31C);
    #1;
    chk("rs2_stall", 32'(load_use_stall), 32'd1);
    step();
    step();

    // Flush and hazard together: flush wins.
    do_reset();
    set_lw(5'd5, 32'h400);
    step();
    set_alu(5'd0, 5'd5, 5'd8, 32'h404);
    id_in.regwrite = 1'b0; id_in.memwrite = 1'b1;
    flush = 1'b1;
    #1;
    chk("fh_stall", 32'(load_use_stall), 32'd0);
    step();
    chk("fh_valid", 32'(ex_valid), 32'd0);
    chk("fh_memwrite", 32'(ex_MemWrite), 32'd0);
    chk("fh_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("fh_bubble_cnt", 32'(bubble_cnt), 32'd0);

    // Saturation: 20 back-to-back flushes.
    for (int i = 0; i < 20; i++) begin
      set_alu(5'd4, 5'd1, 5'd2, 32'h500 + 32'(i * 4));
      flush = 1'b1;
      step();
    end
    chk("flush_sat", 32'(flush_cnt), 32'hF);

    // Async reset mid-cycle with a pending stall, then a normal load.
    set_lw(5'd5, 32'h600);
    step();
    set_alu(5'd6, 5'd5, 5'd7, 32'h604);
    #1;
    chk("pre_rst_stall", 32'(load_use_stall), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_fields", 32'({ex_valid, ex_rd, ex_pc[15:0], ex_RegWrite, ex_WDSel}), 32'd0);
    chk("arst_cnts", 32'({bubble_cnt, flush_cnt}), 32'd0);
    chk("arst_stall", 32'(load_use_stall), 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_valid", 32'(ex_valid), 32'd1);
    chk("post_rst_rd", 32'(ex_rd), 32'd6);
    chk("post_rst_bubble", 32'(bubble_cnt), 32'd0);
    nop();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of bubble/flush event counters.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port id_valid  input  1  ID slot holds a real instruction.
REQ-005 SHALL have ports id_pc, id_rd1, id_rd2, id_imm  input  32 each  PC, rs1 data, rs2 data, extended immediate.
REQ-006 SHALL have ports id_rs1, id_rs2, id_rd  input  5 each  register indices.
REQ-007 SHALL have ports id_use_rs1, id_use_rs2  input  1 each  instruction reads that source.
REQ-008 SHALL have decoder ports id_RegWrite 1, id_MemWrite 1, id_ALUSrc 1, id_ALUOp 5, id_NPCOp 3, id_WDSel 2, id_dm_ctrl 3  input.
REQ-009 SHALL have port flush  input  1  branch/jump taken in EX; kill ID instruction.
REQ-010 SHALL have outputs ex_valid 1, ex_pc/ex_rd1/ex_rd2/ex_imm 32, ex_rs1/ex_rs2/ex_rd 5, ex_RegWrite 1, ex_MemWrite 1, ex_ALUSrc 1, ex_ALUOp 5, ex_NPCOp 3, ex_WDSel 2, ex_dm_ctrl 3  all registered.
REQ-011 SHALL have port load_use_stall  output  1  combinational; freeze PC and IF/ID.
REQ-012 SHALL have ports bubble_cnt, flush_cnt  output  CNT_W each  registered event counters.

Function
REQ-013 SHALL compute hazard = ex_valid & ex_RegWrite & (ex_WDSel==2'b01) & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)) & id_valid.
REQ-014 SHALL drive load_use_stall = hazard & ~flush, same cycle, no register.
REQ-015 SHALL, each rising edge, select exactly one action, priority flush > stall > load.
REQ-016 Flush: SHALL write bubble (all ex_* outputs zero, ex_valid=0) and increment flush_cnt.
REQ-017 Stall (load_use_stall=1): SHALL write bubble and increment bubble_cnt; ID inputs held upstream and re-presented next cycle.
REQ-018 Load: SHALL copy every id_* field to its ex_* counterpart, ex_valid=id_valid, 1-cycle latency.
REQ-019 Load with id_valid=0 SHALL force all ex_* control fields (RegWrite, MemWrite, ALUSrc, ALUOp, NPCOp, WDSel, dm_ctrl) to zero regardless of inputs.
REQ-020 Bubble SHALL be architecturally inert: no register write, no memory write, NPCOp=000.
REQ-021 Counters SHALL saturate at all-ones; no wrap.
REQ-022 Stall SHALL last exactly one cycle per load-use pair: bubble makes ex_valid=0, so hazard deasserts next cycle.
REQ-023 Simultaneous flush and hazard: flush wins, load_use_stall=0, only flush_cnt increments.
REQ-024 x0 destination SHALL never cause a stall.

Reset
REQ-025 reset=1 SHALL immediately (asynchronously) clear all ex_* outputs, ex_valid, bubble_cnt, flush_cnt to zero.
REQ-026 load_use_stall SHALL be 0 during reset, following from ex_valid=0.
REQ-027 Reset asserted mid-stall SHALL drop the pending stall; first edge after release performs a normal load.

Verification
REQ-028 Load: id_valid=1, id_pc=0x100, id_ALUOp=5'b00011, id_RegWrite=1 -> next edge ex_pc=0x100, ex_ALUOp=00011, ex_RegWrite=1, ex_valid=1.
REQ-029 Load-use: EX holds lw x5 (WDSel=01, rd=5); ID add x6,x5,x7 with use_rs1=1 -> load_use_stall=1 same cycle; next edge ex_valid=0, bubble_cnt=1; following edge add loads, stall=0.
REQ-030 No false stall: EX lw x0 vs ID rs1=0, or EX addi x5 (WDSel=00) vs ID rs1=5 -> load_use_stall=0, bubble_cnt unchanged.
REQ-031 Flush+hazard same cycle -> load_use_stall=0, ex_valid=0, ex_MemWrite=0, flush_cnt=1, bubble_cnt=0.
REQ-032 Saturation: CNT_W=4, 20 consecutive flushes -> flush_cnt stays 4'hF.
REQ-033 Async reset mid-cycle with ex_valid=1, counters nonzero -> all outputs zero before next clock edge.
